// File: rtl/spio_uart_sync_filter_pkg.sv
// Shared definitions for the UART-side input conditioner: filter step decode
// and parameter limits.
package spio_uart_sync_filter_pkg;

  localparam int FILTER_LEN_MAX = 65536;

  typedef enum logic [1:0] {
    FLT_HOLD,
    FLT_AGREE,
    FLT_COUNT,
    FLT_ACCEPT
  } flt_action_e;

  // Disabled ticks hold everything; an agreeing sample always wins over the counter.
  function automatic flt_action_e flt_decode(input logic sample,
                                             input logic differ,
                                             input logic at_last);
    if (!sample) return FLT_HOLD;
    if (!differ) return FLT_AGREE;
    return at_last ? FLT_ACCEPT : FLT_COUNT;
  endfunction

endpackage

// File: rtl/spio_uart_sync_filter_chan.sv
// One conditioned channel: synchroniser chain, persistence filter and
// registered rise/fall pulses.
module spio_uart_sync_filter_chan
  import spio_uart_sync_filter_pkg::*;
#(
  parameter int   NUM_STAGES    = 2,
  parameter int   FILTER_LEN    = 4,
  parameter logic INITIAL_VALUE = 1'b0
) (
  input  logic CLK_IN,
  input  logic RESET_IN,
  input  logic sample_en_i,
  input  logic data_i,
  output logic data_o,
  output logic rise_o,
  output logic fall_o
);

  function automatic int clog2_min1(input int v);
    int w;
    w = 1;
    while ((w < 31) && ((1 << w) < v)) w = w + 1;
    return w;
  endfunction

  localparam int              CNT_W    = clog2_min1(FILTER_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

  if (NUM_STAGES < 1) begin : g_bad_stages
    $error("spio_uart_sync_filter_chan: NUM_STAGES must be >= 1");
  end
  if ((FILTER_LEN < 1) || (FILTER_LEN > FILTER_LEN_MAX)) begin : g_bad_filter
    $error("spio_uart_sync_filter_chan: FILTER_LEN must be in 1..65536");
  end

  logic [NUM_STAGES-1:0] sync_q;
  logic                  sync_w;
  logic                  filt_q, filt_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  rise_q, rise_d;
  logic                  fall_q, fall_d;
  flt_action_e           act;

  // Chain is free-running; only the last stage feeds the filter.
  always_ff @(posedge CLK_IN or posedge RESET_IN) begin
    if (RESET_IN) begin
      sync_q <= {NUM_STAGES{INITIAL_VALUE}};
    end else begin
      sync_q[0] <= data_i;
      for (int unsigned k = 1; k < NUM_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
    end
  end

  assign sync_w = sync_q[NUM_STAGES-1];

  always_comb begin
    act    = flt_decode(sample_en_i, sync_w != filt_q, cnt_q == CNT_LAST);
    filt_d = filt_q;
    cnt_d  = cnt_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    unique case (act)
      FLT_HOLD:  ;
      FLT_AGREE: cnt_d = '0;
      FLT_COUNT: cnt_d = cnt_q + CNT_W'(1);
      FLT_ACCEPT: begin
        filt_d = sync_w;
        cnt_d  = '0;
        rise_d = sync_w;
        fall_d = ~sync_w;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK_IN or posedge RESET_IN) begin
    if (RESET_IN) begin
      filt_q <= INITIAL_VALUE;
      cnt_q  <= '0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign data_o = filt_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/spio_uart_sync_filter.sv
// Multi-bit synchronise-and-deglitch conditioner for asynchronous UART pins;
// each bit is an independent channel sharing the sample tick.
module spio_uart_sync_filter
  import spio_uart_sync_filter_pkg::*;
#(
  parameter int                  NUM_BITS      = 1,
  parameter int                  NUM_STAGES    = 2,
  parameter int                  FILTER_LEN    = 4,
  parameter logic [NUM_BITS-1:0] INITIAL_VALUE = '0
) (
  input  logic                CLK_IN,
  input  logic                RESET_IN,
  input  logic                SAMPLE_EN_IN,
  input  logic [NUM_BITS-1:0] DATA_IN,
  output logic [NUM_BITS-1:0] DATA_OUT,
  output logic [NUM_BITS-1:0] RISE_OUT,
  output logic [NUM_BITS-1:0] FALL_OUT
);

  if (NUM_BITS < 1) begin : g_bad_bits
    $error("spio_uart_sync_filter: NUM_BITS must be >= 1");
  end
  if (FILTER_LEN > FILTER_LEN_MAX) begin : g_bad_len
    $error("spio_uart_sync_filter: FILTER_LEN exceeds supported maximum");
  end

  for (genvar i = 0; i < NUM_BITS; i++) begin : g_chan
    spio_uart_sync_filter_chan #(
      .NUM_STAGES   (NUM_STAGES),
      .FILTER_LEN   (FILTER_LEN),
      .INITIAL_VALUE(INITIAL_VALUE[i])
    ) u_chan (
      .CLK_IN     (CLK_IN),
      .RESET_IN   (RESET_IN),
      .sample_en_i(SAMPLE_EN_IN),
      .data_i     (DATA_IN[i]),
      .data_o     (DATA_OUT[i]),
      .rise_o     (RISE_OUT[i]),
      .fall_o     (FALL_OUT[i])
    );
  end

endmodule

// File: tb/tb_spio_uart_sync_filter.sv
// Bench for spio_uart_sync_filter: three configurations checked every cycle
// against a sliding-window reference model, plus directed latency/glitch cases.
module tb_spio_uart_sync_filter;

  localparam int NDUT = 3;
  localparam int NB [NDUT] = '{4, 2, 1};
  localparam int NS [NDUT] = '{2, 3, 1};
  localparam int FL [NDUT] = '{4, 3, 1};
  localparam logic [3:0] IV [NDUT] = '{4'b1010, 4'b0010, 4'b0001};

  logic       CLK_IN = 1'b0;
  logic       RESET_IN;
  logic       en_a, en_b, en_c;
  logic [3:0] din_a, out_a, rise_a, fall_a;
  logic [1:0] din_b, out_b, rise_b, fall_b;
  logic [0:0] din_c, out_c, rise_c, fall_c;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK_IN = ~CLK_IN;

  spio_uart_sync_filter #(
    .NUM_BITS(4), .NUM_STAGES(2), .FILTER_LEN(4), .INITIAL_VALUE(4'b1010)
  ) u_dut_a (
    .CLK_IN(CLK_IN), .RESET_IN(RESET_IN), .SAMPLE_EN_IN(en_a), .DATA_IN(din_a),
    .DATA_OUT(out_a), .RISE_OUT(rise_a), .FALL_OUT(fall_a)
  );

  spio_uart_sync_filter #(
    .NUM_BITS(2), .NUM_STAGES(3), .FILTER_LEN(3), .INITIAL_VALUE(2'b10)
  ) u_dut_b (
    .CLK_IN(CLK_IN), .RESET_IN(RESET_IN), .SAMPLE_EN_IN(en_b), .DATA_IN(din_b),
    .DATA_OUT(out_b), .RISE_OUT(rise_b), .FALL_OUT(fall_b)
  );

  spio_uart_sync_filter #(
    .NUM_BITS(1), .NUM_STAGES(1), .FILTER_LEN(1), .INITIAL_VALUE(1'b1)
  ) u_dut_c (
    .CLK_IN(CLK_IN), .RESET_IN(RESET_IN), .SAMPLE_EN_IN(en_c), .DATA_IN(din_c),
    .DATA_OUT(out_c), .RISE_OUT(rise_c), .FALL_OUT(fall_c)
  );

  // Reference: delay line for the synchroniser, then accept a new level once the
  // last FILTER_LEN enabled samples all disagree with the current output.
  logic [3:0] m_out  [NDUT];
  logic [3:0] m_rise [NDUT];
  logic [3:0] m_fall [NDUT];
  logic [3:0] m_pipe [NDUT][4];
  logic [3:0] m_hist [NDUT][4];
  int         m_hcnt [NDUT][4];

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] din_of(input int d);
    case (d)
      0:       return din_a;
      1:       return {2'b00, din_b};
      default: return {3'b000, din_c};
    endcase
  endfunction

  function automatic logic en_of(input int d);
    case (d)
      0:       return en_a;
      1:       return en_b;
      default: return en_c;
    endcase
  endfunction

  function automatic logic [3:0] obs(input int d, input int sel);
    logic [3:0] o, r, f;
    case (d)
      0:       begin o = out_a;           r = rise_a;           f = fall_a;           end
      1:       begin o = {2'b00, out_b};  r = {2'b00, rise_b};  f = {2'b00, fall_b};  end
      default: begin o = {3'b000, out_c}; r = {3'b000, rise_c}; f = {3'b000, fall_c}; end
    endcase
    case (sel)
      0:       return o;
      1:       return r;
      default: return f;
    endcase
  endfunction

  task automatic model_reset();
    for (int d = 0; d < NDUT; d++) begin
      m_out[d]  = IV[d];
      m_rise[d] = '0;
      m_fall[d] = '0;
      for (int k = 0; k < 4; k++) begin
        m_pipe[d][k] = IV[d];
        m_hist[d][k] = '0;
        m_hcnt[d][k] = 0;
      end
    end
  endtask

  task automatic model_edge();
    for (int d = 0; d < NDUT; d++) begin
      logic [3:0] s;
      s = m_pipe[d][NS[d]-1];
      m_rise[d] = '0;
      m_fall[d] = '0;
      if (en_of(d)) begin
        for (int b = 0; b < NB[d]; b++) begin
          bit ok;
          m_hist[d][b] = {m_hist[d][b][2:0], s[b]};
          if (m_hcnt[d][b] < 4) m_hcnt[d][b]++;
          ok = (m_hcnt[d][b] >= FL[d]);
          for (int j = 0; j < FL[d]; j++) begin
            if (m_hist[d][b][j] == m_out[d][b]) ok = 1'b0;
          end
          if (ok) begin
            m_out[d][b]  = s[b];
            m_rise[d][b] = s[b];
            m_fall[d][b] = ~s[b];
            m_hcnt[d][b] = 0;
          end
        end
      end
      for (int k = 3; k > 0; k--) m_pipe[d][k] = m_pipe[d][k-1];
      m_pipe[d][0] = din_of(d);
    end
  endtask

  task automatic check_all();
    for (int d = 0; d < NDUT; d++) begin
      chk_val($sformatf("dut%0d_DATA_OUT", d), 32'(obs(d, 0)), 32'(m_out[d]));
      chk_val($sformatf("dut%0d_RISE_OUT", d), 32'(obs(d, 1)), 32'(m_rise[d]));
      chk_val($sformatf("dut%0d_FALL_OUT", d), 32'(obs(d, 2)), 32'(m_fall[d]));
    end
  endtask

  // Inputs change on the falling edge; outputs are checked there too.
  task automatic cycle();
    @(posedge CLK_IN);
    if (!RESET_IN) model_edge();
    @(negedge CLK_IN);
    check_all();
  endtask

  task automatic apply_reset(input int n);
    RESET_IN = 1'b1;
    #1;
    model_reset();
    check_all();
    for (int i = 0; i < n; i++) begin
      din_a = 4'($urandom);
      din_b = 2'($urandom);
      din_c = 1'($urandom);
      cycle();
    end
    RESET_IN = 1'b0;
  endtask

  task automatic wait_change(input string tag, input int d, input int b, input int exp);
    logic [3:0] t;
    logic       start;
    int         lat;
    t     = obs(d, 0);
    start = t[b];
    lat   = 0;
    do begin
      cycle();
      lat++;
      t = obs(d, 0);
    end while ((t[b] == start) && (lat < 30));
    chk_val({tag, "_latency"}, 32'(lat), 32'(exp));
    t = obs(d, start ? 2 : 1);
    chk_val({tag, "_pulse"}, 32'(t[b]), 32'd1);
  endtask

  task automatic glitch(input int len, input int exp_edges);
    int         nr, nf;
    logic [3:0] t;
    nr = 0;
    nf = 0;
    din_a[0] = 1'b1;
    for (int i = 0; i < len + 14; i++) begin
      if (i == len) din_a[0] = 1'b0;
      cycle();
      t = obs(0, 1);
      if (t[0]) nr++;
      t = obs(0, 2);
      if (t[0]) nf++;
    end
    chk_val($sformatf("glitch%0d_rises", len), 32'(nr), 32'(exp_edges));
    chk_val($sformatf("glitch%0d_falls", len), 32'(nf), 32'(exp_edges));
  endtask

  initial begin
    int         first;
    logic [7:0] pat;
    logic [3:0] t;
    int         idx;

    en_a  = 1'b1;
    en_b  = 1'b1;
    en_c  = 1'b1;
    din_a = '0;
    din_b = '0;
    din_c = '0;

    // Reset held with toggling inputs, then release at the reset values.
    apply_reset(4);
    din_a = 4'b1010;
    din_b = 2'b10;
    din_c = 1'b1;
    repeat (8) cycle();

    // Step latency: NUM_STAGES + FILTER_LEN edges.
    din_a[0] = 1'b1;
    wait_change("a_rise", 0, 0, 6);
    cycle();
    din_a[0] = 1'b0;
    wait_change("a_fall", 0, 0, 6);
    din_b[1] = 1'b0;
    wait_change("b_fall", 1, 1, 6);
    din_c = 1'b0;
    wait_change("c_fall", 2, 0, 2);
    din_c = 1'b1;
    wait_change("c_rise", 2, 0, 2);
    repeat (4) cycle();

    // Glitch rejection just below and at the filter length.
    glitch(3, 0);
    glitch(4, 1);

    // Any agreeing sample restarts the count.
    pat   = 8'b1111_0111;
    first = 0;
    for (int i = 0; i < 20; i++) begin
      din_a[0] = (i < 8) ? pat[i] : 1'b1;
      cycle();
      t = obs(0, 0);
      if (t[0] && (first == 0)) first = i + 1;
    end
    chk_val("counter_clear_accept_edge", 32'(first), 32'd10);
    din_a[0] = 1'b0;
    repeat (8) cycle();

    // Sparse sample tick on the 3-stage / length-3 configuration.
    din_b = 2'b01;
    for (int i = 0; i < 100; i++) begin
      en_b = ((i % 16) == 0);
      cycle();
    end
    t = obs(1, 0);
    chk_val("gated_b_settled", 32'(t), 32'h1);
    en_b = 1'b1;

    // Two channels rising together pulse in the same cycle.
    din_a = 4'b1111;
    repeat (6) cycle();
    t = obs(0, 1);
    chk_val("multi_rise", 32'(t), 32'h5);
    repeat (4) cycle();

    // Reset with filter progress under way, then full latency again.
    din_a = 4'b0000;
    repeat (4) cycle();
    apply_reset(2);
    din_a = 4'b0101;
    din_b = 2'b10;
    din_c = 1'b1;
    wait_change("post_reset", 0, 0, 6);
    repeat (6) cycle();

    // Randomised traffic with sticky inputs, random ticks and occasional resets.
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 7) == 0) din_a[b] = ~din_a[b];
      end
      if ($urandom_range(0, 6) == 0) begin
        idx = int'($urandom_range(0, 1));
        din_b[idx] = ~din_b[idx];
      end
      if ($urandom_range(0, 2) == 0) din_c = ~din_c;
      en_a = ($urandom_range(0, 7) != 0);
      en_b = ($urandom_range(0, 3) != 0);
      en_c = ($urandom_range(0, 1) != 0);
      if ($urandom_range(0, 199) == 0) apply_reset(int'($urandom_range(1, 3)));
      else cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "simulation timeout");
  end

endmodule
